// File: rtl/lcd_cmd_issuer.sv
// Command issuer for LCD_CTRL: buffers host-loaded 4-bit commands and plays them out
// over the cmd/cmd_valid/busy handshake, finishing on LCD_CTRL's done after the write opcode.
module lcd_cmd_issuer #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AW        = 6,
    parameter logic [3:0]  WRITE_CMD = 4'h0,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    ld_cmd,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          start,
    input  logic          busy,
    input  logic          done,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    output logic          running,
    output logic          fin,
    output logic          err_timeout,
    output logic [AW:0]   issued_cnt,
    output logic [AW:0]   fifo_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        DONEW,
        FIN
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [9:0]  TO_LAST  = 10'(TIMEOUT - 1);

    state_t        state;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [9:0]    to_cnt;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign ld_ready   = (fifo_cnt != FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = ld_valid && ld_ready;
    assign pop        = (state == ISSUE) && !fifo_empty;

    // Storage carries no reset; pointer and count reset is what discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ld_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            running     <= 1'b0;
            fin         <= 1'b0;
            err_timeout <= 1'b0;
            issued_cnt  <= '0;
            to_cnt      <= '0;
        end else begin
            cmd_valid <= 1'b0;
            fin       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ISSUE;
                        running     <= 1'b1;
                        issued_cnt  <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!fifo_empty) begin
                        cmd        <= mem[rd_ptr];
                        cmd_valid  <= 1'b1;
                        issued_cnt <= issued_cnt + 1'b1;
                        state      <= GUARD;
                    end else if (!busy) begin
                        state   <= FIN;
                        running <= 1'b0;
                        fin     <= 1'b1;
                    end
                end
                GUARD: begin
                    // busy from LCD_CTRL lags cmd_valid by a cycle, so it is not trusted here
                    to_cnt <= '0;
                    state  <= (cmd == WRITE_CMD) ? DONEW : WAIT;
                end
                WAIT: begin
                    if (!busy) begin
                        state <= ISSUE;
                    end else if (to_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= FIN;
                        running     <= 1'b0;
                        fin         <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONEW: begin
                    if (done) begin
                        state   <= FIN;
                        running <= 1'b0;
                        fin     <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= FIN;
                        running     <= 1'b0;
                        fin         <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
